issue_scoreboard: RTL and testbench
===================================

# issue_scoreboard

In-order, single-issue stage feeding the functional-unit cluster: buffers dispatched instructions in a small FIFO and tracks pending register writes in a scoreboard. It presents the head instruction to the FUs once its operands are free and the target FU is ready. It is the driving end of the FU input handshake and the consuming end of the FU write-back ports: write-backs clear scoreboard entries and wake dependent instructions.

## Interface
Parameters:
- IQ_DEPTH, 4, queue entries; power of two, ≥2
- NR_REGS, 32, architectural integer registers; x0 never busy

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- dispatch_i  in  fu_input_t  instruction from dispatch
- dispatch_i_valid  in  1  dispatch valid
- dispatch_i_ready  out  1  queue can accept
- flush_i  in  1  drop all queued, not-yet-issued instructions
- fuinput_o  out  fu_input_t  head instruction to FUs
- fuinput_o_valid  out  1  head is issuable
- fuinput_i_ready  in  fu_bitvector_t  per-FU ready, indexed by fu_t
- fuoutput_i  in  fu_output_t[NR_WB_PORTS]  write-back results
- fuoutput_i_valid  in  wb_bitvector_t  per-port write-back valid

## Operation
- fu_input_t fields used: fu, id, rd, rs1, rs2, rd_we, rs1_use, rs2_use. fu_output_t field used: id.
- Queue: circular FIFO, pointers log2(IQ_DEPTH)+1 bits, wrap on MSB toggle. dispatch_i_ready = !full && !flush_i; independent of same-cycle issue.
- Push when dispatch_i_valid && dispatch_i_ready. Pop on issue. Push+pop in the same cycle leaves count unchanged.
- Scoreboard: busy[NR_REGS], plus an rd table indexed by id (NR_IDS entries, each rd + valid bit).
- Head is issuable when the queue is non-empty and all of the following hold:
  - rs1 not busy, or !rs1_use
  - rs2 not busy, or !rs2_use
  - rd not busy, or !rd_we, or rd==0 (WAW stall)
- fuinput_o_valid = issuable; fuinput_o = head entry (zero when empty).
- Issue fires when fuinput_o_valid && fuinput_i_ready[head.fu]. On issue with rd_we && rd!=0: set busy[rd], table[id] <= {rd, 1}.
- Write-back on port p (fuoutput_i_valid[p]): if table[fuoutput_i[p].id].valid, clear busy of that rd and clear the table valid bit. Ports are processed in parallel; the WAW stall keeps their rds distinct.
- A write-back with an invalid table entry (store, branch, or rd_we=0) is ignored.
- An issue-set and a write-back-clear of the same register in the same cycle: set wins.
- flush_i empties the queue (pointers reset) on the next edge and does not issue that cycle (fuinput_o_valid forced 0). The scoreboard is untouched, because in-flight results still write back.
- rst: queue empty, busy all 0, table invalid. Outputs: dispatch_i_ready=1, fuinput_o_valid=0, fuinput_o='0.

## Timing
- Dispatch → earliest issue: 1 cycle (entry becomes visible at the head after the push edge).
- Throughput: 1 issue per cycle with independent instructions.
- Write-back → dependent issue: 0 cycles with bypass, 1 cycle without (see Configuration).
- Issue → dependent blocked: busy is visible from the next cycle. The dependent is always a later queue entry, so no same-cycle hazard exists.
- fuinput_o_valid must not depend on fuinput_i_ready (no combinational loop through the FUs).

## Configuration
- ISSUE_WB_BYPASS_EN defined: a register whose write-back is valid this cycle is treated as not busy in the issuable check this same cycle. This is a combinational path fuoutput_i → fuinput_o_valid.
- ISSUE_WB_BYPASS_EN undefined: the issuable check uses only registered busy; wakeup takes 1 cycle.

## Structure
- Package C gains: NR_IDS, iq_ptr_t, and sb_entry_t {rd, valid}.
- Sub-module issue_fifo: parameterised by IQ_DEPTH and payload type. It provides push/pop/flush, full/empty, and head read.
- The scoreboard, rd table and issue logic live in the top module.

## Test plan
- Reset, then dispatch 4 independent ALU ops (ids 0–3) with FU_ALU ready → one issue per cycle on cycles 1–4; dispatch_i_ready stays 1.
- Id 5 writes x7; id 6 reads x7 (rs1_use) → id 6 held until write-back of id 5. With bypass it issues the same cycle as that write-back; without bypass, one cycle later.
- FU_LSU ready=0 with an LSU op at the head plus 4 more dispatches (IQ_DEPTH=4) → queue fills and dispatch_i_ready=0. Raise ready → head issues and dispatch_i_ready returns to 1 the next cycle.
- WAW: id 1 writes x3, id 2 writes x3 → id 2 stalls until id 1's write-back clears busy[3].
- flush_i with 3 queued entries and x9 busy → queue empty next cycle and fuinput_o_valid=0. busy[9] is cleared only by the later write-back.
- rst asserted mid-stall (busy set, queue non-empty) → immediately all busy=0, queue empty, fuinput_o_valid=0.

Source files
------------

// File: rtl/issue_scoreboard_pkg.sv
// Shared types for the in-order issue stage: FU identifiers, the FU
// input/output payloads, queue pointer width and the scoreboard rd-table entry.
package issue_scoreboard_pkg;

    localparam int NR_IDS       = 8;
    localparam int ID_W         = $clog2(NR_IDS);
    localparam int REG_W        = 5;
    localparam int NR_WB_PORTS  = 2;
    localparam int NR_FUS       = 4;
    localparam int IQ_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_LSU = 2'd2,
        FU_BRU = 2'd3
    } fu_t;

    typedef logic [NR_FUS-1:0]            fu_bitvector_t;
    typedef logic [NR_WB_PORTS-1:0]       wb_bitvector_t;
    typedef logic [ID_W-1:0]              id_t;
    typedef logic [REG_W-1:0]             reg_t;
    typedef logic [$clog2(IQ_DEPTH_DEF):0] iq_ptr_t;

    typedef struct packed {
        fu_t  fu;
        id_t  id;
        reg_t rd;
        reg_t rs1;
        reg_t rs2;
        logic rd_we;
        logic rs1_use;
        logic rs2_use;
    } fu_input_t;

    typedef struct packed {
        id_t id;
    } fu_output_t;

    typedef struct packed {
        reg_t rd;
        logic valid;
    } sb_entry_t;

    // True when the instruction produces an architectural result (x0 is never tracked).
    function automatic logic writes_reg(input fu_input_t instr);
        return instr.rd_we && (instr.rd != {REG_W{1'b0}});
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// Circular FIFO holding dispatched instructions. Pointers carry one extra
// wrap bit so full and empty are told apart without a counter.
module issue_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    input  logic flush,
    output logic full,
    output logic empty,
    output T     head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    T            mem_r [DEPTH];

    // Pointer advance; flush discards every queued entry by resetting both pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Payload storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign head  = mem_r[rd_ptr_r[AW-1:0]];

endmodule

// File: rtl/issue_scoreboard.sv
// In-order single-issue stage: instruction queue, register busy scoreboard
// and rd table indexed by instruction id. Write-backs clear busy bits and
// wake the head. Optional macro ISSUE_WB_BYPASS_EN lets a same-cycle
// write-back unblock the head combinationally; without it wakeup takes 1 cycle.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int IQ_DEPTH = 4,
    parameter int NR_REGS  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  fu_input_t     dispatch_i,
    input  logic          dispatch_i_valid,
    output logic          dispatch_i_ready,
    input  logic          flush_i,
    output fu_input_t     fuinput_o,
    output logic          fuinput_o_valid,
    input  fu_bitvector_t fuinput_i_ready,
    input  fu_output_t    fuoutput_i [NR_WB_PORTS],
    input  wb_bitvector_t fuoutput_i_valid
);

    logic                fifo_full_s;
    logic                fifo_empty_s;
    fu_input_t           head_s;
    logic                push_s;
    logic                issuable_s;
    logic                fire_s;
    logic [NR_WB_PORTS-1:0] wb_hit_s;
    logic [NR_REGS-1:0]  wb_clr_mask_s;
    logic [NR_REGS-1:0]  set_mask_s;
    logic [NR_REGS-1:0]  busy_eff_s;
    logic [NR_IDS-1:0]   id_clr_s;
    logic [NR_REGS-1:0]  busy_r;
    sb_entry_t           tbl_r [NR_IDS];

    assign dispatch_i_ready = !fifo_full_s && !flush_i;
    assign push_s           = dispatch_i_valid && dispatch_i_ready;

    issue_fifo #(
        .DEPTH (IQ_DEPTH),
        .T     (fu_input_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (dispatch_i),
        .pop       (fire_s),
        .flush     (flush_i),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head      (head_s)
    );

    // Decode write-backs: which ports hit a live table entry, and which registers/ids they release.
    always_comb begin
        wb_hit_s      = '0;
        wb_clr_mask_s = '0;
        id_clr_s      = '0;
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            wb_hit_s[p] = fuoutput_i_valid[p] && tbl_r[fuoutput_i[p].id].valid;
            for (int r = 0; r < NR_REGS; r++) begin
                wb_clr_mask_s[r] = wb_clr_mask_s[r] |
                    (wb_hit_s[p] && (tbl_r[fuoutput_i[p].id].rd == reg_t'(r)));
            end
            for (int i = 0; i < NR_IDS; i++) begin
                id_clr_s[i] = id_clr_s[i] | (wb_hit_s[p] && (fuoutput_i[p].id == id_t'(i)));
            end
        end
    end

`ifdef ISSUE_WB_BYPASS_EN
    assign busy_eff_s = busy_r & ~wb_clr_mask_s;
`else
    assign busy_eff_s = busy_r;
`endif

    // Head issuability: RAW on used sources and WAW on the destination; never depends on FU ready.
    always_comb begin
        issuable_s = 1'b0;
        if (!fifo_empty_s && !flush_i) begin
            issuable_s = (!head_s.rs1_use || !busy_eff_s[head_s.rs1]) &&
                         (!head_s.rs2_use || !busy_eff_s[head_s.rs2]) &&
                         (!writes_reg(head_s) || !busy_eff_s[head_s.rd]);
        end else begin
            issuable_s = 1'b0;
        end
    end

    // Present the head entry to the FUs, zero when the queue holds nothing.
    always_comb begin
        fuinput_o = '0;
        if (fifo_empty_s) begin
            fuinput_o = '0;
        end else begin
            fuinput_o = head_s;
        end
    end

    assign fuinput_o_valid = issuable_s;
    assign fire_s          = issuable_s && fuinput_i_ready[head_s.fu];

    // Destination register claimed by the instruction issuing this cycle.
    always_comb begin
        set_mask_s = '0;
        if (fire_s && writes_reg(head_s)) begin
            set_mask_s[head_s.rd] = 1'b1;
        end else begin
            set_mask_s = '0;
        end
    end

    // Busy vector: write-backs release, issue claims; a same-cycle claim overrides the release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= '0;
        end else begin
            busy_r <= (busy_r & ~wb_clr_mask_s) | set_mask_s;
        end
    end

    // rd table: record the destination of each issued writer, drop it when its result returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR_IDS; i++) begin
                tbl_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NR_IDS; i++) begin
                if (fire_s && writes_reg(head_s) && (head_s.id == id_t'(i))) begin
                    tbl_r[i] <= '{rd: head_s.rd, valid: 1'b1};
                end else if (id_clr_s[i]) begin
                    tbl_r[i].valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed scenarios followed by randomized
// traffic, all checked every cycle against a queue/array reference model.
`timescale 1ns/1ps
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

    localparam int DEPTH = 4;
`ifdef ISSUE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    fu_input_t     disp;
    logic          disp_v;
    logic          disp_rdy;
    logic          flush;
    fu_input_t     fu_in;
    logic          fu_in_v;
    fu_bitvector_t fu_rdy;
    fu_output_t    wb [NR_WB_PORTS];
    wb_bitvector_t wb_v;

    always #5 clk = ~clk;

    issue_scoreboard #(.IQ_DEPTH(DEPTH), .NR_REGS(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .dispatch_i       (disp),
        .dispatch_i_valid (disp_v),
        .dispatch_i_ready (disp_rdy),
        .flush_i          (flush),
        .fuinput_o        (fu_in),
        .fuinput_o_valid  (fu_in_v),
        .fuinput_i_ready  (fu_rdy),
        .fuoutput_i       (wb),
        .fuoutput_i_valid (wb_v)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int fires_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    fu_input_t iq_m[$];          // queued instructions, oldest first
    int        inflight_m[$];    // ids issued and awaiting write-back
    bit        busy_m[32];
    int        rd_of_id[NR_IDS]; // -1 when the id has no pending register write
    bit        id_used[NR_IDS];

    function automatic bit reg_busy(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (!busy_m[r]) return 1'b0;
        if (BYP) begin
            for (int p = 0; p < NR_WB_PORTS; p++)
                if (wb_v[p] && rd_of_id[wb[p].id] == int'(r)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit m_issuable();
        fu_input_t h;
        if (rst || flush || iq_m.size() == 0) return 1'b0;
        h = iq_m[0];
        if (h.rs1_use && reg_busy(h.rs1)) return 1'b0;
        if (h.rs2_use && reg_busy(h.rs2)) return 1'b0;
        if (h.rd_we && reg_busy(h.rd)) return 1'b0;
        return 1'b1;
    endfunction

    initial begin : model
        bit        acc;
        bit        fire;
        fu_input_t h;
        int        id;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                iq_m.delete();
                inflight_m.delete();
                foreach (busy_m[i]) busy_m[i] = 1'b0;
                foreach (rd_of_id[i]) rd_of_id[i] = -1;
                foreach (id_used[i]) id_used[i] = 1'b0;
            end else begin
                acc  = disp_v && (iq_m.size() < DEPTH) && !flush;
                fire = 1'b0;
                if (m_issuable()) fire = fu_rdy[iq_m[0].fu];
                for (int p = 0; p < NR_WB_PORTS; p++) begin
                    if (wb_v[p]) begin
                        id = int'(wb[p].id);
                        if (rd_of_id[id] >= 0) begin
                            busy_m[rd_of_id[id]] = 1'b0;
                            rd_of_id[id] = -1;
                        end
                        id_used[id] = 1'b0;
                        for (int k = 0; k < inflight_m.size(); k++)
                            if (inflight_m[k] == id) begin
                                inflight_m.delete(k);
                                break;
                            end
                    end
                end
                if (fire) begin
                    h = iq_m.pop_front();
                    if (h.rd_we && h.rd != 5'd0) begin
                        busy_m[h.rd] = 1'b1;
                        rd_of_id[h.id] = int'(h.rd);
                    end
                    inflight_m.push_back(int'(h.id));
                end
                if (flush) begin
                    foreach (iq_m[i]) id_used[iq_m[i].id] = 1'b0;
                    iq_m.delete();
                end
                if (acc) begin
                    iq_m.push_back(disp);
                    id_used[disp.id] = 1'b1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        forever begin
            @(negedge clk);
            chk("dispatch_ready", 64'(disp_rdy), 64'((iq_m.size() < DEPTH) && !flush));
            chk("issue_valid", 64'(fu_in_v), 64'(m_issuable()));
            if (iq_m.size() == 0) chk("head_empty", 64'(fu_in), 64'd0);
            else                  chk("issue_head", 64'(fu_in), 64'(iq_m[0]));
            if (fu_in_v && fu_rdy[fu_in.fu]) fires_seen++;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    function automatic fu_input_t mk(input int f, input int id, input int rd, input int rs1,
                                     input int rs2, input bit we, input bit u1, input bit u2);
        fu_input_t x;
        x.fu      = fu_t'(f);
        x.id      = id_t'(id);
        x.rd      = reg_t'(rd);
        x.rs1     = reg_t'(rs1);
        x.rs2     = reg_t'(rs2);
        x.rd_we   = we;
        x.rs1_use = u1;
        x.rs2_use = u2;
        return x;
    endfunction

    task automatic drive_wb(input int pct);
        int  used[$];
        int  k;
        bit  dup;
        wb_v = '0;
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            if (inflight_m.size() > 0 && $urandom_range(99) < pct) begin
                k = $urandom_range(inflight_m.size() - 1);
                dup = 1'b0;
                foreach (used[j]) if (used[j] == k) dup = 1'b1;
                if (!dup) begin
                    wb[p].id = id_t'(inflight_m[k]);
                    wb_v[p]  = 1'b1;
                    used.push_back(k);
                end
            end
        end
    endtask

    task automatic wb_one(input int id);
        wb_v     = '0;
        wb[0].id = id_t'(id);
        wb_v[0]  = 1'b1;
    endtask

    task automatic drain();
        fu_rdy = '1;
        disp_v = 1'b0;
        flush  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (iq_m.size() == 0 && inflight_m.size() == 0) begin
                wb_v = '0;
                return;
            end
            drive_wb(100);
            cyc();
        end
        wb_v = '0;
        chk("drain_timeout", 64'(iq_m.size() + inflight_m.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int free_ids[$];
        rst    = 1'b1;
        disp   = '0;
        disp_v = 1'b0;
        flush  = 1'b0;
        fu_rdy = '1;
        wb_v   = '0;
        for (int p = 0; p < NR_WB_PORTS; p++) wb[p] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();

        // four independent ALU ops issue back to back
        fires_seen = 0;
        for (int i = 0; i < 4; i++) begin
            disp   = mk(FU_ALU, i, 10 + i, 1, 2, 1'b1, 1'b1, 1'b1);
            disp_v = 1'b1;
            settle();
            chk("t1_dispatch_ready", 64'(disp_rdy), 64'd1);
            cyc();
        end
        disp_v = 1'b0;
        settle();
        chk("t1_issue_count", 64'(fires_seen), 64'd4);
        cyc();
        drain();

        // RAW: id 6 reads x7 written by id 5
        disp = mk(FU_ALU, 5, 7, 0, 0, 1'b1, 1'b0, 1'b0); disp_v = 1'b1; cyc();
        disp = mk(FU_ALU, 6, 20, 7, 0, 1'b1, 1'b1, 1'b0); cyc();
        disp_v = 1'b0;
        repeat (3) begin
            settle();
            chk("t2_raw_blocked", 64'(fu_in_v), 64'd0);
            cyc();
        end
        wb_one(5);
        settle();
        chk("t2_wake_same_cycle", 64'(fu_in_v), 64'(BYP));
        cyc();
        wb_v = '0;
        settle();
        chk("t2_wake_next_cycle", 64'(fu_in_v), 64'(!BYP));
        cyc();
        drain();

        // LSU not ready: queue fills, then drains one
        fu_rdy[FU_LSU] = 1'b0;
        disp = mk(FU_LSU, 0, 0, 1, 0, 1'b0, 1'b1, 1'b0); disp_v = 1'b1; cyc();
        for (int i = 1; i < 4; i++) begin
            disp = mk(FU_ALU, i, 0, 0, 0, 1'b0, 1'b0, 1'b0);
            cyc();
        end
        disp = mk(FU_ALU, 4, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t3_full_not_ready", 64'(disp_rdy), 64'd0);
        cyc();
        fu_rdy[FU_LSU] = 1'b1;
        settle();
        chk("t3_ready_still_low", 64'(disp_rdy), 64'd0);
        cyc();
        settle();
        chk("t3_ready_returns", 64'(disp_rdy), 64'd1);
        cyc();
        disp_v = 1'b0;
        drain();

        // WAW on x3
        disp = mk(FU_ALU, 1, 3, 0, 0, 1'b1, 1'b0, 1'b0); disp_v = 1'b1; cyc();
        disp = mk(FU_MUL, 2, 3, 0, 0, 1'b1, 1'b0, 1'b0); cyc();
        disp_v = 1'b0;
        repeat (2) begin
            settle();
            chk("t4_waw_stall", 64'(fu_in_v), 64'd0);
            cyc();
        end
        wb_one(1);
        settle();
        chk("t4_waw_release", 64'(fu_in_v), 64'(BYP));
        cyc();
        wb_v = '0;
        drain();

        // flush with three queued entries while x9 is busy
        disp = mk(FU_ALU, 0, 9, 0, 0, 1'b1, 1'b0, 1'b0); disp_v = 1'b1; cyc();
        disp_v = 1'b0; cyc();
        fu_rdy = '0;
        for (int i = 1; i < 4; i++) begin
            disp = mk(FU_MUL, i, 12, 0, 0, 1'b1, 1'b0, 1'b0); disp_v = 1'b1; cyc();
        end
        disp_v = 1'b0;
        fu_rdy = '1;
        flush  = 1'b1;
        settle();
        chk("t5_flush_no_issue", 64'(fu_in_v), 64'd0);
        chk("t5_flush_no_dispatch", 64'(disp_rdy), 64'd0);
        cyc();
        flush = 1'b0;
        settle();
        chk("t5_empty_after_flush", 64'(fu_in), 64'd0);
        disp = mk(FU_ALU, 4, 0, 9, 0, 1'b0, 1'b1, 1'b0); disp_v = 1'b1; cyc();
        disp_v = 1'b0;
        repeat (2) begin
            settle();
            chk("t5_busy_survives", 64'(fu_in_v), 64'd0);
            cyc();
        end
        wb_one(0);
        settle();
        chk("t5_wb_wakes", 64'(fu_in_v), 64'(BYP));
        cyc();
        wb_v = '0;
        drain();

        // reset in the middle of a stall
        disp = mk(FU_ALU, 0, 7, 0, 0, 1'b1, 1'b0, 1'b0); disp_v = 1'b1; cyc();
        disp = mk(FU_ALU, 1, 8, 7, 0, 1'b1, 1'b1, 1'b0); cyc();
        disp_v = 1'b0; cyc();
        rst = 1'b1;
        settle();
        chk("t6_rst_valid", 64'(fu_in_v), 64'd0);
        chk("t6_rst_head", 64'(fu_in), 64'd0);
        chk("t6_rst_ready", 64'(disp_rdy), 64'd1);
        cyc();
        rst = 1'b0;
        disp = mk(FU_ALU, 2, 0, 7, 0, 1'b0, 1'b1, 1'b0); disp_v = 1'b1; cyc();
        disp_v = 1'b0;
        settle();
        chk("t6_busy_cleared", 64'(fu_in_v), 64'd1);
        cyc();
        drain();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int f = 0; f < NR_FUS; f++) fu_rdy[f] = ($urandom_range(3) != 0);
            flush  = ($urandom_range(49) == 0);
            disp_v = 1'b0;
            free_ids.delete();
            for (int i = 0; i < NR_IDS; i++) if (!id_used[i]) free_ids.push_back(i);
            if (free_ids.size() > 0 && $urandom_range(9) < 7) begin
                disp = mk($urandom_range(3), free_ids[$urandom_range(free_ids.size() - 1)],
                          $urandom_range(7), $urandom_range(7), $urandom_range(7),
                          1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
                disp_v = 1'b1;
            end
            drive_wb(40);
            cyc();
        end
        flush = 1'b0;
        disp_v = 1'b0;
        drain();
        settle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
